// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: tracks the text cell under the scan, fetches the character
// and its font row through external RAM/decoder/ROM, and serialises the row to RGB444.
module text_pixel_gen #(
  parameter int          ASCII_WIDTH  = 8,
  parameter int          ADDR_WIDTH   = 11,
  parameter int          CHARA_HEIGHT = 11,
  parameter int          COLS         = 80,
  parameter int          ROWS         = 43,
  parameter int          TADDR_WIDTH  = 12,
  parameter logic        SYNC_POL     = 1'b0,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   de_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  output logic [TADDR_WIDTH-1:0] text_addr,
  input  logic [ASCII_WIDTH-1:0] text_data,
  output logic [ASCII_WIDTH-1:0] chara_ascii,
  output logic [3:0]             chara_line,
  input  logic [ADDR_WIDTH-1:0]  chara_line_addr,
  output logic [ADDR_WIDTH-1:0]  font_addr,
  input  logic [7:0]             font_data,
  output logic [11:0]            rgb_out,
  output logic                   de_out,
  output logic                   hsync_out,
  output logic                   vsync_out
);

  localparam int                     COL_W     = $clog2(COLS + 1);
  localparam int                     ROW_W     = $clog2(ROWS + 1);
  localparam logic [COL_W-1:0]       COL_LIM   = COL_W'(COLS);
  localparam logic [ROW_W-1:0]       ROW_LIM   = ROW_W'(ROWS);
  localparam logic [TADDR_WIDTH-1:0] ROW_STEP  = TADDR_WIDTH'(COLS);
  localparam logic [3:0]             LAST_LINE = 4'(CHARA_HEIGHT - 1);
  localparam logic                   SYNC_IDLE = ~SYNC_POL;

  function automatic logic [COL_W-1:0] sat_inc_col(input logic [COL_W-1:0] v);
    return (v >= COL_LIM) ? v : v + COL_W'(1);
  endfunction

  function automatic logic [11:0] pixel_color(input logic vld, input logic txt, input logic px);
    if (!vld || !txt) return 12'h000;
    return px ? FG_COLOR : BG_COLOR;
  endfunction

  logic [2:0]             pix_cnt;
  logic [COL_W-1:0]       col_cnt;
  logic [3:0]             line_cnt;
  logic [ROW_W-1:0]       row_cnt;
  logic [TADDR_WIDTH-1:0] row_base;
  logic                   de_d;
  logic                   frame_ok;
  logic                   in_text;

  // Output stays blank after a reset until a vsync re-establishes the frame position.
  assign in_text = de_in && frame_ok && (col_cnt < COL_LIM) && (row_cnt < ROW_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt  <= '0;
      col_cnt  <= '0;
      line_cnt <= '0;
      row_cnt  <= '0;
      row_base <= '0;
      de_d     <= 1'b0;
      frame_ok <= 1'b0;
    end else begin
      de_d <= de_in;
      if (de_in) begin
        pix_cnt <= pix_cnt + 3'd1;
        if (pix_cnt == 3'd7) col_cnt <= sat_inc_col(col_cnt);
      end else begin
        pix_cnt <= '0;
        col_cnt <= '0;
      end
      if (vsync_in == SYNC_POL) begin
        line_cnt <= '0;
        row_cnt  <= '0;
        row_base <= '0;
        frame_ok <= 1'b1;
      end else if (de_d && !de_in) begin
        if (line_cnt == LAST_LINE) begin
          line_cnt <= '0;
          if (row_cnt < ROW_LIM) begin
            row_cnt  <= row_cnt + ROW_W'(1);
            row_base <= row_base + ROW_STEP;
          end
        end else begin
          line_cnt <= line_cnt + 4'd1;
        end
      end
    end
  end

  logic [3:0] line_p1;
  logic [2:0] pix_p1, pix_p2, pix_p3;
  logic       txt_p1, txt_p2, txt_p3, txt_p4;
  logic       vld_p1, vld_p2, vld_p3, vld_p4;
  logic       hs_p1, hs_p2, hs_p3, hs_p4;
  logic       vs_p1, vs_p2, vs_p3, vs_p4;
  logic       bit_p4;

  always_ff @(posedge clk) begin
    if (rst) begin
      text_addr   <= '0;
      line_p1     <= '0;
      pix_p1      <= '0;
      txt_p1      <= 1'b0;
      vld_p1      <= 1'b0;
      hs_p1       <= SYNC_IDLE;
      vs_p1       <= SYNC_IDLE;
      chara_ascii <= '0;
      chara_line  <= '0;
      pix_p2      <= '0;
      txt_p2      <= 1'b0;
      vld_p2      <= 1'b0;
      hs_p2       <= SYNC_IDLE;
      vs_p2       <= SYNC_IDLE;
      font_addr   <= '0;
      pix_p3      <= '0;
      txt_p3      <= 1'b0;
      vld_p3      <= 1'b0;
      hs_p3       <= SYNC_IDLE;
      vs_p3       <= SYNC_IDLE;
      bit_p4      <= 1'b0;
      txt_p4      <= 1'b0;
      vld_p4      <= 1'b0;
      hs_p4       <= SYNC_IDLE;
      vs_p4       <= SYNC_IDLE;
      rgb_out     <= '0;
      de_out      <= 1'b0;
      hsync_out   <= SYNC_IDLE;
      vsync_out   <= SYNC_IDLE;
    end else begin
      // S1: text RAM address; held outside the text area so it never leaves the array
      if (in_text) text_addr <= row_base + TADDR_WIDTH'(col_cnt);
      line_p1 <= line_cnt;
      pix_p1  <= pix_cnt;
      txt_p1  <= in_text;
      vld_p1  <= de_in;
      hs_p1   <= hsync_in;
      vs_p1   <= vsync_in;
      // S2: character code and glyph line to the decoder
      chara_ascii <= text_data;
      chara_line  <= txt_p1 ? line_p1 : 4'd0;
      pix_p2      <= pix_p1;
      txt_p2      <= txt_p1;
      vld_p2      <= vld_p1;
      hs_p2       <= hs_p1;
      vs_p2       <= vs_p1;
      // S3: font ROM address
      font_addr <= chara_line_addr;
      pix_p3    <= pix_p2;
      txt_p3    <= txt_p2;
      vld_p3    <= vld_p2;
      hs_p3     <= hs_p2;
      vs_p3     <= vs_p2;
      // S4: pick this pixel's bit out of the font row
      bit_p4 <= font_data[3'd7 - pix_p3];
      txt_p4 <= txt_p3;
      vld_p4 <= vld_p3;
      hs_p4  <= hs_p3;
      vs_p4  <= vs_p3;
      // S5: colour and aligned timing
      rgb_out   <= pixel_color(vld_p4, txt_p4, bit_p4);
      de_out    <= vld_p4;
      hsync_out <= hs_p4;
      vsync_out <= vs_p4;
    end
  end

endmodule

// File: tb/tb_text_pixel_gen.sv
// Bench for text_pixel_gen: drives a small VGA-like scan, models text RAM, decoder and font
// ROM, and checks every output cycle against a frame-position model plus literal anchors.
module tb_text_pixel_gen;

  localparam logic SP   = 1'b0;
  localparam logic SI   = 1'b1;
  localparam int   MAXC = 8192;
  localparam logic [11:0] PAT [8] = '{12'h000, 12'h000, 12'h000, 12'hFFF,
                                      12'hFFF, 12'h000, 12'h000, 12'h000};

  logic        clk = 1'b0;
  logic        rst, de_in, hsync_in, vsync_in;
  logic [11:0] text_addr;
  logic [7:0]  text_data;
  logic [7:0]  chara_ascii;
  logic [3:0]  chara_line;
  logic [10:0] chara_line_addr;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [11:0] rgb_out;
  logic        de_out, hsync_out, vsync_out;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  ram  [4096];
  logic [7:0]  font [2048];
  logic [14:0] exp_val [MAXC];
  bit          exp_v   [MAXC];
  logic [11:0] hist_taddr [MAXC];
  logic [3:0]  hist_cline [MAXC];
  logic [11:0] hist_rgb   [MAXC];
  int          lcyc [648];

  int m_x, m_line;
  bit m_ok, m_de_prev;

  text_pixel_gen dut (
    .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .text_addr(text_addr), .text_data(text_data), .chara_ascii(chara_ascii),
    .chara_line(chara_line), .chara_line_addr(chara_line_addr), .font_addr(font_addr),
    .font_data(font_data), .rgb_out(rgb_out), .de_out(de_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out)
  );

  function automatic logic [10:0] decode(input logic [7:0] c, input logic [3:0] l);
    int g;
    g = (c <= 8'd31 || c > 8'd127) ? 0 : int'(c) - 32;
    return 11'(g * 11 + int'(l));
  endfunction

  // The registered addresses act as the memories' address registers: data follows one clock later.
  assign text_data       = ram[text_addr];
  assign chara_line_addr = decode(chara_ascii, chara_line);
  assign font_data       = font[font_addr];

  function automatic logic [11:0] model_rgb(input int x, input int ln);
    int col, row, gl;
    logic [7:0] f;
    col = x / 8;
    row = ln / 11;
    gl  = ln % 11;
    if (col >= 80 || row >= 43) return 12'h000;
    f = font[decode(ram[row * 80 + col], 4'(gl))];
    return f[7 - (x % 8)] ? 12'hFFF : 12'h000;
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, got, want);
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      hist_taddr[cyc] <= text_addr;
      hist_cline[cyc] <= chara_line;
      hist_rgb[cyc]   <= rgb_out;
    end
  end

  always @(negedge clk) begin
    if (cyc < MAXC && exp_v[cyc])
      check("pipe_out{de,hs,vs,rgb}", int'({de_out, hsync_out, vsync_out, rgb_out}),
            int'(exp_val[cyc]));
  end

  task automatic set_exp(input int c, input logic [14:0] v);
    if (c < MAXC) begin
      exp_val[c] = v;
      exp_v[c]   = 1'b1;
    end
  endtask

  // Drives one input cycle; n is the clock edge that samples it.
  task automatic step(input logic r, input logic d, input logic hs, input logic vs, output int n);
    logic [11:0] px;
    @(posedge clk);
    #1;
    rst = r; de_in = d; hsync_in = hs; vsync_in = vs;
    n = cyc + 1;
    if (r) begin
      m_ok = 1'b0; m_x = 0; m_line = 0; m_de_prev = 1'b0;
      for (int k = 0; k < 5; k++) set_exp(n + k, {1'b0, SI, SI, 12'h000});
    end else begin
      px = (d && m_ok) ? model_rgb(m_x, m_line) : 12'h000;
      set_exp(n + 4, {d, hs, vs, px});
      if (vs == SP) begin
        m_line = 0;
        m_ok   = 1'b1;
      end else if (m_de_prev && !d) begin
        m_line++;
      end
      m_x = d ? m_x + 1 : 0;
      m_de_prev = d;
    end
  endtask

  task automatic do_line(input int w, input int rst_px, input bit vs_end);
    int n;
    for (int x = 0; x < w; x++) begin
      step(x == rst_px, 1'b1, SI, SI, n);
      lcyc[x] = n;
    end
    for (int k = 0; k < 8; k++)
      step(1'b0, 1'b0, (k == 3 || k == 4) ? SP : SI, (k == 0 && vs_end) ? SP : SI, n);
  endtask

  task automatic idle(input int cnt, input logic vs);
    int n;
    for (int k = 0; k < cnt; k++) step(1'b0, 1'b0, SI, vs, n);
  endtask

  task automatic check_pattern(input string name);
    for (int k = 0; k < 8; k++) check(name, int'(hist_rgb[lcyc[k] + 4]), int'(PAT[k]));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) ram[i] = 8'(32 + (i * 7) % 96);
    ram[0] = 8'h41;
    ram[2] = 8'h05;
    ram[3] = 8'hC8;
    for (int a = 0; a < 2048; a++) font[a] = 8'((a * 37) ^ (a >> 2));
    font[363] = 8'h18;
    font[364] = 8'hFF;
    font[365] = 8'h81;

    rst = 1'b1; de_in = 1'b0; hsync_in = SI; vsync_in = SI;
    m_ok = 1'b0; m_x = 0; m_line = 0; m_de_prev = 1'b0;
    repeat (3) step(1'b1, 1'b0, SI, SI, n);
    step(1'b0, 1'b0, SI, SI, n);
    check("reset_rgb", int'(rgb_out), 0);
    check("reset_de", int'(de_out), 0);
    check("reset_hsync", int'(hsync_out), 1);
    check("reset_vsync", int'(vsync_out), 1);
    check("reset_taddr", int'(text_addr), 0);

    idle(4, SI); idle(3, SP); idle(4, SI);

    // frame 1, line 0: 'A' glyph row 0
    do_line(24, -1, 1'b0);
    check_pattern("first_line_rgb");
    check("first_line_taddr", int'(hist_taddr[lcyc[0]]), 0);
    check("px8_taddr", int'(hist_taddr[lcyc[8]]), 1);
    check("first_line_cline", int'(hist_cline[lcyc[0] + 1]), 0);

    // line 1: 648 px wide, cell 80 is outside the text area
    do_line(648, -1, 1'b0);
    for (int k = 640; k < 648; k++) check("cell80_rgb", int'(hist_rgb[lcyc[k] + 4]), 0);
    check("cell80_taddr_hold", int'(hist_taddr[lcyc[647]]), 79);

    for (int l = 2; l < 10; l++) do_line(16, -1, 1'b0);
    do_line(24, -1, 1'b0);
    check("line10_cline", int'(hist_cline[lcyc[0] + 1]), 10);
    check("line10_taddr", int'(hist_taddr[lcyc[0]]), 0);
    do_line(24, -1, 1'b0);
    check("line11_taddr", int'(hist_taddr[lcyc[0]]), 80);
    check("line11_cline", int'(hist_cline[lcyc[0] + 1]), 0);
    for (int l = 12; l < 30; l++) do_line(16, -1, 1'b0);
    do_line(16, -1, 1'b1);

    // frame 2 after a vsync coinciding with the de falling edge
    do_line(24, -1, 1'b0);
    check("vs_edge_taddr", int'(hist_taddr[lcyc[0]]), 0);
    check("vs_edge_cline", int'(hist_cline[lcyc[0] + 1]), 0);
    check_pattern("vs_edge_rgb");

    // reset pulse at pixel 10 of line 1, then blank until the next vsync
    do_line(24, 10, 1'b0);
    check("rst_next_rgb", int'(hist_rgb[lcyc[10]]), 0);
    do_line(24, -1, 1'b0);
    check("rst_blank_rgb", int'(hist_rgb[lcyc[0] + 4]), 0);
    idle(4, SI); idle(3, SP); idle(4, SI);
    do_line(24, -1, 1'b0);
    check_pattern("resume_rgb");
    check("resume_taddr", int'(hist_taddr[lcyc[0]]), 0);
    idle(10, SI);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not complete, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
